// File: rtl/coherence_bus_arbiter.sv
// Registered bus arbiter for the coherence controller: MSB, LSB or round-robin
// winner selection, grant hold with optional preemption, one-cycle turnaround.
module coherence_bus_arbiter #(
   parameter int    NUM_REQ  = 8,
   parameter string MODE     = "RR",
   parameter int    HOLD_MAX = 0,
   parameter int    IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] request,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_index,
   output logic               grant_valid,
   output logic               preempt
);

   localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
   localparam bit IS_MSB = (MODE == "MSB");
   localparam bit IS_LSB = (MODE == "LSB");

   typedef enum logic [1:0] {IDLE, GRANTED, TURNAROUND} state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   hold_cnt;
   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] eligible;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic               owner_req;
   logic               others;

   assign eligible  = request & ~mask;
   assign win_found = |eligible;
   assign owner_req = |(request & grant);
   assign others    = |(request & ~grant);

   // Later loop iterations overwrite earlier ones, so each loop runs from
   // the lowest-priority candidate to the highest.
   always_comb begin
      int j;
      logic [IDX_W-1:0] idx;
      j = 0;
      idx = '0;
      win_idx = '0;
      if (IS_MSB) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'(i);
            if (eligible[idx]) win_idx = idx;
         end
      end else if (IS_LSB) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'(i);
            if (eligible[idx]) win_idx = idx;
         end
      end else begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = IDX_W'(j);
            if (eligible[idx]) win_idx = idx;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= '0;
         grant_index <= '0;
         grant_valid <= 1'b0;
         preempt     <= 1'b0;
         rr_ptr      <= IDX_W'(NUM_REQ - 1);
         hold_cnt    <= '0;
         mask        <= '0;
      end else begin
         preempt <= 1'b0;
         unique case (state)
            IDLE, TURNAROUND: begin
               mask <= '0;
               if (win_found) begin
                  state       <= GRANTED;
                  grant       <= NUM_REQ'(1) << win_idx;
                  grant_index <= win_idx;
                  grant_valid <= 1'b1;
                  rr_ptr      <= win_idx;
                  hold_cnt    <= CNT_W'(1);
               end else begin
                  state <= IDLE;
               end
            end
            GRANTED: begin
               if (!owner_req) begin
                  state       <= TURNAROUND;
                  grant       <= '0;
                  grant_index <= '0;
                  grant_valid <= 1'b0;
               end else if (HOLD_MAX != 0 && hold_cnt == HOLD_LIM && others) begin
                  state       <= TURNAROUND;
                  grant       <= '0;
                  grant_index <= '0;
                  grant_valid <= 1'b0;
                  preempt     <= 1'b1;
                  mask        <= grant;
               end else if (HOLD_MAX != 0 && hold_cnt != HOLD_LIM) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomised scoreboard bench: three arbiter configurations driven in
// parallel and compared against a behavioural tenure model.
module tb_coherence_bus_arbiter;

   typedef struct packed {
      logic [7:0] grant;
      logic [2:0] idx;
      logic       valid;
      logic       pre;
   } exp_t;
   typedef exp_t [2:0] cyc_t;

   logic       clock;
   logic       reset;
   logic [7:0] rq [3];

   logic [4:0] g0;
   logic [2:0] i0;
   logic       v0, p0;
   logic [3:0] g1;
   logic [1:0] i1;
   logic       v1, p1;
   logic [5:0] g2;
   logic [2:0] i2;
   logic       v2, p2;

   coherence_bus_arbiter #(.NUM_REQ(5), .MODE("RR"), .HOLD_MAX(3)) dut0 (
      .clock(clock), .reset(reset), .request(rq[0][4:0]),
      .grant(g0), .grant_index(i0), .grant_valid(v0), .preempt(p0));

   coherence_bus_arbiter #(.NUM_REQ(4), .MODE("MSB"), .HOLD_MAX(0)) dut1 (
      .clock(clock), .reset(reset), .request(rq[1][3:0]),
      .grant(g1), .grant_index(i1), .grant_valid(v1), .preempt(p1));

   coherence_bus_arbiter #(.NUM_REQ(6), .MODE("LSB"), .HOLD_MAX(2)) dut2 (
      .clock(clock), .reset(reset), .request(rq[2][5:0]),
      .grant(g2), .grant_index(i2), .grant_valid(v2), .preempt(p2));

   exp_t act [3];
   always_comb begin
      act[0] = '{grant: {3'b0, g0}, idx: i0, valid: v0, pre: p0};
      act[1] = '{grant: {4'b0, g1}, idx: {1'b0, i1}, valid: v1, pre: p1};
      act[2] = '{grant: {2'b0, g2}, idx: i2, valid: v2, pre: p2};
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int nassert = 0;
   int nfail   = 0;
   cyc_t sb [$];

   // Model: mode 0=RR 1=MSB 2=LSB; owner -1 means no tenure in progress.
   int nn [3] = '{5, 4, 6};
   int md [3] = '{0, 1, 2};
   int hm [3] = '{3, 0, 2};
   int owner [3];
   int last [3];
   int masked [3];
   int ten [3];
   bit pre [3];

   function automatic void model_reset(int d);
      owner[d]  = -1;
      last[d]   = nn[d] - 1;
      masked[d] = -1;
      ten[d]    = 0;
      pre[d]    = 1'b0;
   endfunction

   function automatic int pick(int d, logic [7:0] r);
      logic [7:0] e;
      int i;
      e = r;
      if (masked[d] >= 0) e[masked[d]] = 1'b0;
      if (md[d] == 1) begin
         for (int k = nn[d] - 1; k >= 0; k--) if (e[k]) return k;
      end else if (md[d] == 2) begin
         for (int k = 0; k < nn[d]; k++) if (e[k]) return k;
      end else begin
         for (int k = 1; k <= nn[d]; k++) begin
            i = (last[d] + k) % nn[d];
            if (e[i]) return i;
         end
      end
      return -1;
   endfunction

   function automatic void model_step(int d, logic [7:0] r);
      logic [7:0] oth;
      int w;
      if (owner[d] >= 0) begin
         oth = r;
         oth[owner[d]] = 1'b0;
         if (!r[owner[d]]) begin
            owner[d]  = -1;
            pre[d]    = 1'b0;
            masked[d] = -1;
         end else if (hm[d] > 0 && ten[d] == hm[d] && oth != 0) begin
            masked[d] = owner[d];
            owner[d]  = -1;
            pre[d]    = 1'b1;
         end else begin
            pre[d] = 1'b0;
            if (ten[d] < hm[d]) ten[d]++;
         end
      end else begin
         pre[d] = 1'b0;
         w = pick(d, r);
         masked[d] = -1;
         if (w >= 0) begin
            owner[d] = w;
            last[d]  = w;
            ten[d]   = 1;
         end
      end
   endfunction

   function automatic exp_t expv(int d);
      exp_t e;
      e.grant = (owner[d] >= 0) ? (8'd1 << owner[d]) : 8'd0;
      e.idx   = (owner[d] >= 0) ? 3'(owner[d]) : 3'd0;
      e.valid = (owner[d] >= 0);
      e.pre   = pre[d];
      return e;
   endfunction

   // Monitor: every cycle the DUTs present a result, compare it with the
   // oldest scoreboard entry and check the grant invariants.
   logic [7:0] prevg [3] = '{8'd0, 8'd0, 8'd0};
   int mcyc = 0;
   always begin
      cyc_t c;
      @(posedge clock);
      #1;
      mcyc++;
      if (sb.size() != 0) begin
         c = sb.pop_front();
         for (int d = 0; d < 3; d++) begin
            nassert++;
            if (act[d] !== c[d]) begin
               nfail++;
               $display("FAIL dut%0d cyc%0d outputs: got grant=%h idx=%0d valid=%b pre=%b, want grant=%h idx=%0d valid=%b pre=%b",
                        d, mcyc, act[d].grant, act[d].idx, act[d].valid, act[d].pre,
                        c[d].grant, c[d].idx, c[d].valid, c[d].pre);
            end
            nassert++;
            if (!$onehot0(act[d].grant) || act[d].valid !== (act[d].grant != 0)) begin
               nfail++;
               $display("FAIL dut%0d cyc%0d onehot: got grant=%h valid=%b, want one-hot/zero with matching valid",
                        d, mcyc, act[d].grant, act[d].valid);
            end
            nassert++;
            if (prevg[d] != 0 && act[d].grant != 0 && act[d].grant != prevg[d]) begin
               nfail++;
               $display("FAIL dut%0d cyc%0d turnaround: got grant %h -> %h, want a zero cycle between owners",
                        d, mcyc, prevg[d], act[d].grant);
            end
            prevg[d] = act[d].grant;
         end
      end
   end

   function automatic void randomize_req();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < nn[d]; i++) begin
            if (rq[d][i]) begin
               if ($urandom_range(0, 5) == 0) rq[d][i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               rq[d][i] = 1'b1;
            end
         end
   endfunction

   function automatic void all_req();
      for (int d = 0; d < 3; d++) rq[d] = 8'((9'd1 << nn[d]) - 9'd1);
   endfunction

   initial begin
      cyc_t c;
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         rq[d] = 8'd0;
         model_reset(d);
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         if (cyc == 3 || cyc == 1503) begin
            reset = 1'b1;
            all_req();
         end else if (cyc == 1500) begin
            #2;
            reset = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) begin
               nassert++;
               if (act[d] !== '0) begin
                  nfail++;
                  $display("FAIL dut%0d async_reset: got grant=%h idx=%0d valid=%b pre=%b, want all zero",
                           d, act[d].grant, act[d].idx, act[d].valid, act[d].pre);
               end
            end
         end else if (reset) begin
            randomize_req();
         end
         @(posedge clock);
         for (int d = 0; d < 3; d++) begin
            if (!reset) model_reset(d);
            else model_step(d, rq[d]);
            c[d] = expv(d);
         end
         sb.push_back(c);
      end
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
